uart_tx_ctrl: RTL and testbench

- UART transmit controller that sits directly upstream of the serial pin and owns the per-bit sequencing of each frame.
- Accepts one byte at a time over a valid/ready handshake and generates its own baud tick from the system clock.
- Serialises each byte as 1 start bit, DATA_BITS data bits (LSB first) and STOP_BITS stop bits.
- Signals frame completion with a one-cycle uart_done pulse, which the RISC-V core's UART MMIO status logic consumes.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_baud_gen.sv | 35 +++
 rtl/uart_tx_ctrl.sv | 128 ++++++++++++
 tb/tb_uart_tx_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit path.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_tx_state_t;

   // 50 MHz system clock at 115200 baud
   localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick generator: one-cycle bit_tick every CLKS_PER_BIT clocks while enabled.
module uart_baud_gen #(
   parameter int unsigned CLKS_PER_BIT = uart_pkg::DEFAULT_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic reset_n,
   input  logic enable,
   output logic bit_tick
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign bit_tick = enable && (cnt_q == CNT_MAX);

   // Next count: parked at zero when disabled, wraps after the tick
   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (!enable || bit_tick) begin
         cnt_d = '0;
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: valid/ready byte intake, start/data/stop sequencing,
// registered serial output and a one-cycle completion pulse.
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 tx_valid,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ready,
   output logic                 tx_busy,
   output logic                 uart_done,
   output logic                 tx
);

   localparam int unsigned IDX_W = $clog2(DATA_BITS);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
   localparam logic STOP_LAST = (STOP_BITS == 2);

   if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2)
   begin : g_param_check
      $error("uart_tx_ctrl: illegal parameter combination");
   end

   uart_tx_state_t       state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 stop_q, stop_d;
   logic                 tx_q, tx_d;
   logic                 done_q, done_d;
   logic                 bit_tick;
   logic                 accept;

   uart_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_gen (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (state_q != IDLE),
      .bit_tick(bit_tick)
   );

   assign accept = tx_valid && (state_q == IDLE);

   // State, datapath and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         shift_q <= '0;
         idx_q   <= '0;
         stop_q  <= 1'b0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         stop_q  <= stop_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
      end
   end

   // Next-state, shift register and bit/stop counters
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      stop_d  = stop_q;
      case (state_q)
         IDLE: begin
            idx_d  = '0;
            stop_d = 1'b0;
            if (accept) begin
               state_d = START;
               shift_d = tx_data;
            end
         end
         START: begin
            if (bit_tick) begin
               state_d = DATA;
               idx_d   = '0;
            end
         end
         DATA: begin
            if (bit_tick) begin
               shift_d = shift_q >> 1;
               idx_d   = idx_q + IDX_W'(1);
               if (idx_q == IDX_LAST) begin
                  state_d = STOP;
                  stop_d  = 1'b0;
               end
            end
         end
         STOP: begin
            if (bit_tick) begin
               if (stop_q == STOP_LAST) begin
                  state_d = IDLE;
               end else begin
                  stop_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output decode; tx is computed from the next state so the pin comes straight off a flop
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
      done_d = (state_q == STOP) && (state_d == IDLE);
   end

   assign tx        = tx_q;
   assign uart_done = done_q;
   assign tx_ready  = (state_q == IDLE);
   assign tx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: one instance with 1 stop bit, one with 2,
// both driven by the same stimulus and compared against a frame-position model.
module tb_uart_tx_ctrl;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic [1:0] txv, rdy, bsy, dnv;

   int checks = 0;
   int errors = 0;

   // Model: position within the frame in clocks (-1 when idle), frame bits, done flag
   int         pos[2] = '{-1, -1};
   logic [11:0] fb[2];
   logic       mdone[2] = '{1'b0, 1'b0};
   int         flen[2] = '{10, 11};

   // Observation buffers for directed checks
   logic [1:0] r_tx[100], r_rdy[100], r_bsy[100], r_dn[100];

   always #5 clk = ~clk;

   uart_tx_ctrl #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS   (8),
      .STOP_BITS   (1)
   ) u_dut0 (
      .clk      (clk),
      .reset_n  (reset_n),
      .tx_valid (tx_valid),
      .tx_data  (tx_data),
      .tx_ready (rdy[0]),
      .tx_busy  (bsy[0]),
      .uart_done(dnv[0]),
      .tx       (txv[0])
   );

   uart_tx_ctrl #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS   (8),
      .STOP_BITS   (2)
   ) u_dut1 (
      .clk      (clk),
      .reset_n  (reset_n),
      .tx_valid (tx_valid),
      .tx_data  (tx_data),
      .tx_ready (rdy[1]),
      .tx_busy  (bsy[1]),
      .uart_done(dnv[1]),
      .tx       (txv[1])
   );

   task automatic chk(input string nm, input int k, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0d: got %b expected %b", nm, k, act, exp);
      end
   endtask

   // Frame layout: bit 0 start (0), bits 1..8 data LSB first, remaining bits stop (1)
   function automatic logic [11:0] mk_frame(input logic [7:0] d);
      logic [11:0] f;
      f = '1;
      f[0] = 1'b0;
      f[8:1] = d;
      return f;
   endfunction

   // Model update on every clock edge
   always @(posedge clk or negedge reset_n) begin
      for (int i = 0; i < 2; i++) begin
         if (!reset_n) begin
            pos[i]   <= -1;
            mdone[i] <= 1'b0;
         end else begin
            mdone[i] <= 1'b0;
            if (pos[i] < 0) begin
               if (tx_valid) begin
                  fb[i]  <= mk_frame(tx_data);
                  pos[i] <= 0;
               end
            end else if (pos[i] == flen[i] * CPB - 1) begin
               pos[i]   <= -1;
               mdone[i] <= 1'b1;
            end else begin
               pos[i] <= pos[i] + 1;
            end
         end
      end
   end

   // Per-cycle comparison against the model, mid-cycle
   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("model_tx%0d", i), $time, txv[i], (pos[i] < 0) ? 1'b1 : fb[i][pos[i] / CPB]);
            chk($sformatf("model_ready%0d", i), $time, rdy[i], pos[i] < 0);
            chk($sformatf("model_busy%0d", i), $time, bsy[i], pos[i] >= 0);
            chk($sformatf("model_done%0d", i), $time, dnv[i], mdone[i]);
         end
      end
   end

   // Present a byte, then record n cycles; cycle 1 is the first after acceptance
   task automatic run_obs(input logic [7:0] d, input int n, input int drop_at,
                          input logic [7:0] d2, input int d2_at);
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = d;
      @(posedge clk);
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         r_tx[k]  = txv;
         r_rdy[k] = rdy;
         r_bsy[k] = bsy;
         r_dn[k]  = dnv;
         if (k == d2_at) tx_data = d2;
         if (k == drop_at) tx_valid = 1'b0;
      end
   endtask

   initial begin
      logic [9:0] exp_a5;
      exp_a5   = 10'b1101001010;
      reset_n  = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      repeat (3) @(negedge clk);
      #1 reset_n = 1'b1;

      // Idle after reset
      repeat (20) @(negedge clk);
      chk("reset_tx", 0, txv[0] & txv[1], 1'b1);
      chk("reset_ready", 0, rdy[0] & rdy[1], 1'b1);
      chk("reset_busy", 0, bsy[0] | bsy[1], 1'b0);
      chk("reset_done", 0, dnv[0] | dnv[1], 1'b0);

      // Single frame 0xA5; tx_data changes right after acceptance and must be ignored
      run_obs(8'hA5, 46, 1, 8'h3C, 1);
      for (int c = 1; c <= 40; c++) chk("a5_tx", c, r_tx[c][0], exp_a5[(c - 1) / 4]);
      chk("a5_done40", 40, r_dn[40][0], 1'b0);
      chk("a5_done41", 41, r_dn[41][0], 1'b1);
      chk("a5_done42", 42, r_dn[42][0], 1'b0);
      chk("a5_ready40", 40, r_rdy[40][0], 1'b0);
      chk("a5_ready41", 41, r_rdy[41][0], 1'b1);
      chk("a5_ready10", 10, r_rdy[10][0], 1'b0);
      for (int c = 37; c <= 44; c++) chk("stop2_tx", c, r_tx[c][1], 1'b1);
      chk("stop2_done41", 41, r_dn[41][1], 1'b0);
      chk("stop2_done45", 45, r_dn[45][1], 1'b1);
      chk("stop2_ready44", 44, r_rdy[44][1], 1'b0);
      repeat (5) @(negedge clk);

      // Back-to-back 0x00 then 0xFF with tx_valid held
      run_obs(8'h00, 80, 46, 8'hFF, 1);
      for (int c = 5; c <= 36; c++) chk("b2b_zero", c, r_tx[c][0], 1'b0);
      chk("b2b_ready41", 41, r_rdy[41][0], 1'b1);
      chk("b2b_done41", 41, r_dn[41][0], 1'b1);
      chk("b2b_tx41", 41, r_tx[41][0], 1'b1);
      for (int c = 42; c <= 45; c++) chk("b2b_start", c, r_tx[c][0], 1'b0);
      chk("b2b_ready42", 42, r_rdy[42][0], 1'b0);
      chk("b2b_busy42", 42, r_bsy[42][0], 1'b1);
      for (int c = 46; c <= 77; c++) chk("b2b_ones", c, r_tx[c][0], 1'b1);
      chk("b2b_stop2_done45", 45, r_dn[45][1], 1'b1);
      chk("b2b_stop2_start46", 46, r_tx[46][1], 1'b0);
      repeat (20) @(negedge clk);

      // Reset during data bit 3 of 0x37 (bit 3 is 0, so tx is low at that moment)
      run_obs(8'h37, 18, 1, 8'h00, 1);
      chk("mid_pre_tx", 18, r_tx[18][0], 1'b0);
      #1 reset_n = 1'b0;
      #1;
      chk("mid_async_tx0", 18, txv[0], 1'b1);
      chk("mid_async_tx1", 18, txv[1], 1'b1);
      chk("mid_async_ready", 18, rdy[0] & rdy[1], 1'b1);
      chk("mid_async_busy", 18, bsy[0] | bsy[1], 1'b0);
      chk("mid_async_done", 18, dnv[0] | dnv[1], 1'b0);
      repeat (2) @(negedge clk);
      #1 reset_n = 1'b1;
      repeat (3) @(negedge clk);

      // Randomised traffic: bursty valid and data that changes every cycle
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         tx_valid = ($urandom_range(0, 3) != 0);
         tx_data  = 8'($urandom);
      end
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (100) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
